// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared states and constants for the imem loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR_LO  = 3'd1,
        HDR_HI  = 3'd2,
        PAYLOAD = 3'd3,
        CHECK   = 3'd4,
        DONE    = 3'd5,
        ERROR   = 3'd6
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [7:0] CSUM_SEED = 8'h00;

endpackage

// File: rtl/loader_word_packer.sv
// rtl/loader_word_packer.sv - little-endian byte-to-word packer
module loader_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data_byte,
    input  logic        shift,
    input  logic        clear,
    output logic [31:0] word,
    output logic        word_complete
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  idx;
    logic [23:0] sreg;

    // The completing byte is presented combinationally so the top can
    // register the whole word on the same edge as the 4th handshake.
    assign word          = {data_byte, sreg};
    assign word_complete = shift && (idx == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx  <= 2'd0;
            sreg <= 24'd0;
        end else if (clear) begin
            idx  <= 2'd0;
            sreg <= 24'd0;
        end else if (shift) begin
            idx  <= idx + 2'd1;
            sreg <= {data_byte, sreg[23:8]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader for instruction memory
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_byte_valid,
    input  logic [7:0]        i_byte,
    output logic              o_byte_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_core_reset,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error,
    output logic [ADDR_W:0]   o_words_loaded
);

    localparam logic [CNT_W:0] MAX_WORDS = {{CNT_W{1'b0}}, 1'b1} << ADDR_W;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  hdr_count;
    logic [7:0]        csum;
    logic              xfer;
    logic              start_ok;
    logic              shift;
    logic              last_word;
    logic              enter_done;
    logic              enter_error;
    logic [31:0]       pk_word;
    logic              pk_done;

    assign xfer      = i_byte_valid && o_byte_ready;
    assign start_ok  = i_start && (state == IDLE || state == DONE || state == ERROR);
    assign shift     = xfer && (state == PAYLOAD);
    assign hdr_count = CNT_W'({i_byte, count[7:0]});
    assign last_word = (CNT_W'(o_words_loaded) + CNT_W'(1)) == count;

    loader_word_packer u_packer (
        .clk           (clk),
        .reset         (reset),
        .data_byte     (i_byte),
        .shift         (shift),
        .clear         (start_ok),
        .word          (pk_word),
        .word_complete (pk_done)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: if (i_start) state_nxt = HDR_LO;
            HDR_LO:            if (xfer) state_nxt = HDR_HI;
            HDR_HI: begin
                if (xfer) begin
                    if ({1'b0, hdr_count} > MAX_WORDS) state_nxt = ERROR;
                    else if (hdr_count == '0)          state_nxt = CHECK;
                    else                               state_nxt = PAYLOAD;
                end
            end
            PAYLOAD:           if (pk_done && last_word) state_nxt = CHECK;
            CHECK:             if (xfer) state_nxt = (i_byte == csum) ? DONE : ERROR;
            default:           state_nxt = IDLE;
        endcase
    end

    assign enter_done  = (state == CHECK) && (state_nxt == DONE);
    assign enter_error = (state == HDR_HI || state == CHECK) && (state_nxt == ERROR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            o_byte_ready   <= 1'b0;
            o_imem_we      <= 1'b0;
            o_imem_addr    <= '0;
            o_imem_wdata   <= 32'd0;
            o_core_reset   <= 1'b1;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_error        <= 1'b0;
            o_words_loaded <= '0;
            count          <= '0;
            csum           <= CSUM_SEED;
        end else begin
            state        <= state_nxt;
            o_byte_ready <= (state_nxt == HDR_LO) || (state_nxt == HDR_HI) ||
                            (state_nxt == PAYLOAD) || (state_nxt == CHECK);
            o_imem_we    <= 1'b0;

            if (start_ok) begin
                o_core_reset   <= 1'b1;
                o_busy         <= 1'b1;
                o_done         <= 1'b0;
                o_error        <= 1'b0;
                o_words_loaded <= '0;
                csum           <= CSUM_SEED;
            end

            if (state == HDR_LO && xfer) count[7:0] <= i_byte;
            if (state == HDR_HI && xfer) count      <= hdr_count;
            if (shift)                   csum       <= csum ^ i_byte;

            if (pk_done) begin
                o_imem_we      <= 1'b1;
                o_imem_addr    <= o_words_loaded[ADDR_W-1:0];
                o_imem_wdata   <= pk_word;
                o_words_loaded <= o_words_loaded + 1'b1;
            end

            // The checksum byte can only be accepted after the last word
            // completed, so done is always registered after its write.
            if (enter_done) begin
                o_done       <= 1'b1;
                o_busy       <= 1'b0;
                o_core_reset <= 1'b0;
            end
            if (enter_error) begin
                o_error <= 1'b1;
                o_busy  <= 1'b0;
            end
        end
    end

endmodule
